// File: rtl/dg_pkg.sv
// Shared types and widths for the data-generator blocks: pattern modes,
// data widths and the sequencer state encoding.
package dg_pkg;

  localparam int PATTERN_DATA_WIDTH = 32;
  localparam int C_AXI_DATA_WIDTH   = 64;

  typedef enum logic [2:0] {
    PAT_FIXED   = 3'd0,
    PAT_INCR    = 3'd1,
    PAT_WALK1   = 3'd2,
    PAT_WALK0   = 3'd3,
    PAT_LFSR    = 3'd4,
    PAT_CHECKER = 3'd5
  } pattern_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } dg_seq_state_t;

endpackage

// File: rtl/dg_sat_cnt.sv
// W-bit counter with synchronous clear and saturating increment.
// Clear wins over increment so a new run always starts from zero.
module dg_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dg_seq_ctrl.sv
// Run sequencer for the pattern generator/checker pair: INIT strobe, N data_en
// cycles, drain window, done pulse. DG_SEQ_CTRL_ERR_STOP_EN makes a RUN mismatch abort.
module dg_seq_ctrl
  import dg_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  pattern_t                      cmd_mode,
  input  logic [PATTERN_DATA_WIDTH-1:0] cmd_word,
  input  logic [CNT_W-1:0]              cmd_num_words,
  input  logic                          abort,
  output logic                          pattern_init,
  output pattern_t                      pattern_mode,
  output logic [PATTERN_DATA_WIDTH-1:0] pattern_word,
  output logic                          data_en,
  output logic                          wrd_cntr_rst,
  input  logic                          msmatch_err,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  output logic [CNT_W-1:0]              words_sent,
  output logic [CNT_W-1:0]              err_cnt
);

  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  dg_seq_state_t    state_reg;
  logic [CNT_W-1:0] num_words_reg;
  logic [DRN_W-1:0] drain_cnt_reg;

  logic accept;
  logic run_stop;
  logic err_inc;

  assign accept = cmd_valid && cmd_ready;

`ifdef DG_SEQ_CTRL_ERR_STOP_EN
  assign run_stop = abort || msmatch_err;
`else
  assign run_stop = abort;
`endif

  // Mismatches only count while a run is live; IDLE/DONE noise is ignored.
  assign err_inc = msmatch_err &&
                   ((state_reg == ST_INIT) || (state_reg == ST_RUN) || (state_reg == ST_DRAIN));

  dg_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .inc   (err_inc),
    .count (err_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      num_words_reg <= '0;
      drain_cnt_reg <= '0;
      cmd_ready     <= 1'b1;
      pattern_init  <= 1'b0;
      pattern_mode  <= PAT_FIXED;
      pattern_word  <= '0;
      data_en       <= 1'b0;
      wrd_cntr_rst  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      words_sent    <= '0;
    end else begin
      pattern_init <= 1'b0;
      wrd_cntr_rst <= 1'b0;
      done         <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            pattern_mode  <= cmd_mode;
            pattern_word  <= cmd_word;
            num_words_reg <= cmd_num_words;
            words_sent    <= '0;
            aborted       <= 1'b0;
            cmd_ready     <= 1'b0;
            busy          <= 1'b1;
            if (cmd_num_words == '0) begin
              state_reg <= ST_DONE;
              done      <= 1'b1;
            end else begin
              state_reg    <= ST_INIT;
              pattern_init <= 1'b1;
              wrd_cntr_rst <= 1'b1;
            end
          end
        end
        ST_INIT: begin
          if (abort) begin
            state_reg     <= ST_DRAIN;
            drain_cnt_reg <= DRN_LAST;
            aborted       <= 1'b1;
          end else begin
            state_reg  <= ST_RUN;
            data_en    <= 1'b1;
            words_sent <= CNT_W'(1);
          end
        end
        ST_RUN: begin
          // words_sent already counts the cycle in flight, so equality marks the last one
          // and takes priority over a coinciding stop request.
          if (words_sent == num_words_reg) begin
            state_reg     <= ST_DRAIN;
            drain_cnt_reg <= DRN_LAST;
            data_en       <= 1'b0;
          end else if (run_stop) begin
            state_reg     <= ST_DRAIN;
            drain_cnt_reg <= DRN_LAST;
            data_en       <= 1'b0;
            aborted       <= 1'b1;
          end else begin
            words_sent <= words_sent + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_reg == '0) begin
            state_reg <= ST_DONE;
            done      <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
          data_en   <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/dg_seq_ctrl.md
DG_SEQ_CTRL -- requirements
Module: dg_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of word-count and error-count fields.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 2, post-run cycles during which msmatch_err is still sampled (≥1).
REQ-003 SHALL use one clock, clk; reset is rst_n, asynchronous, active-low.
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  controller can accept a command.
REQ-008 cmd_mode  in  pattern_t (3)  pattern mode for the run.
REQ-009 cmd_word  in  PATTERN_DATA_WIDTH  pattern seed word.
REQ-010 cmd_num_words  in  CNT_W  number of data_en cycles to issue.
REQ-011 abort  in  1  request early termination of the current run.
REQ-012 pattern_init  out  1  generator load strobe.
REQ-013 pattern_mode  out  pattern_t  latched mode to generator.
REQ-014 pattern_word  out  PATTERN_DATA_WIDTH  latched seed to generator.
REQ-015 data_en  out  1  generator advance enable.
REQ-016 wrd_cntr_rst  out  1  generator word-counter reset strobe.
REQ-017 msmatch_err  in  1  checker mismatch flag, one per bad word.
REQ-018 busy  out  1  run in progress (state ≠ IDLE).
REQ-019 done  out  1  one-cycle completion pulse.
REQ-020 aborted  out  1  last run ended early; valid from done until next accept.
REQ-021 words_sent  out  CNT_W  data_en cycles issued in current/last run.
REQ-022 err_cnt  out  CNT_W  mismatches counted in current/last run.

Function
REQ-023 SHALL implement FSM states IDLE, INIT, RUN, DRAIN, DONE; all outputs registered.
REQ-024 cmd_ready SHALL be 1 only in IDLE; accept occurs when cmd_valid && cmd_ready.
REQ-025 On accept SHALL latch mode/word/num_words and clear words_sent, err_cnt, aborted.
REQ-026 Accept with cmd_num_words=0 SHALL go IDLE→DONE with no pattern_init, wrd_cntr_rst or data_en.
REQ-027 Otherwise IDLE→INIT; in INIT pattern_init=1 and wrd_cntr_rst=1 for exactly one cycle, then RUN.
REQ-028 RUN SHALL hold data_en=1 for exactly num_words consecutive cycles, incrementing words_sent each cycle, then DRAIN.
REQ-029 DRAIN SHALL hold data_en=0 for DRAIN_CYCLES cycles, then DONE.
REQ-030 DONE SHALL last one cycle with done=1, then IDLE.
REQ-031 Latency: accept at edge T → pattern_init high cycle T+1, data_en cycles T+2..T+1+N, done cycle T+2+N+DRAIN_CYCLES.
REQ-032 err_cnt SHALL increment on each cycle msmatch_err=1 in INIT, RUN or DRAIN; saturate at all-ones; ignore msmatch_err in IDLE/DONE.
REQ-033 abort in INIT or RUN SHALL force DRAIN next cycle (data_en low that cycle), set aborted; abort in IDLE, DRAIN, DONE SHALL be ignored.
REQ-034 abort and the final RUN cycle coinciding SHALL complete normally, aborted=0.
REQ-035 pattern_mode/pattern_word SHALL hold latched values until next accept.

Reset
REQ-036 rst_n low SHALL force IDLE, cmd_ready=1 after release, and pattern_init, data_en, wrd_cntr_rst, busy, done, aborted=0, words_sent, err_cnt, pattern_word=0, pattern_mode=0.
REQ-037 Reset mid-run SHALL drop data_en asynchronously; no done pulse follows.

Configuration
REQ-038 Macro DG_SEQ_CTRL_ERR_STOP_EN defined: msmatch_err=1 in RUN SHALL act as abort (REQ-033), still counted.
REQ-039 Macro undefined: mismatches SHALL only be counted; run always completes num_words.

Structure
REQ-040 dg_pkg SHALL hold pattern_t, PATTERN_DATA_WIDTH, C_AXI_DATA_WIDTH and new enum dg_seq_state_t.
REQ-041 err_cnt SHALL use sub-module dg_sat_cnt (CNT_W-bit clear/increment saturating counter).

Verification
REQ-042 Accept mode=2, word=0xA5, N=4, DRAIN_CYCLES=2 → pattern_init 1 cycle, data_en 4 cycles, done 8 cycles after accept, words_sent=4, err_cnt=0.
REQ-043 N=0 → done one cycle after accept; data_en and pattern_init never asserted.
REQ-044 N=10, abort at 3rd data_en cycle → data_en 3 cycles only, aborted=1, words_sent=3, done after DRAIN.
REQ-045 N=6, msmatch_err on 2 RUN cycles and 1 DRAIN cycle → err_cnt=3; with DG_SEQ_CTRL_ERR_STOP_EN, data_en stops after first error, aborted=1.
REQ-046 rst_n low during RUN with N=20 → data_en 0 immediately, all outputs at reset values, next command runs normally.
REQ-047 CNT_W=4, msmatch_err held high across N=15 run → err_cnt saturates at 15.
